// File: rtl/l2_neuron_layer.sv
// l2_neuron_layer: layer-2 inference stage, decaying input traces feeding a three-neuron MAC and threshold winner spike
// Ports:
//   i_clk, i_rst_n   clock (posedge) and asynchronous active-low reset
//   i_event[6:1]     layer-1 spike pulses; each loads its input trace with p_ts_max
//   i_decay_tick     strobe that decrements every trace by p_decay, saturating at 0
//   i_weights        3 neurons x 6 inputs x p_width, neuron n input k at ((n-1)*6+(k-1))*p_width
//   i_thresholds     3 x (2*p_width+4), neuron n at (n-1)*(2*p_width+4)
//   o_ts             6 x (p_width+1) trace snapshot of the current/last evaluation
//   o_lv             3 x (2*p_width+4) potentials of the last evaluation
//   o_spikeout[3:1]  one-hot winner spike, held p_spike_clks cycles
//   o_busy           high whenever the FSM is not idle
// Optional feature: define L2_REFRACTORY_EN to add a refractory period after each spike.
module l2_neuron_layer #(
  parameter int p_width      = 8,
  parameter int p_ts_max     = 'hff,
  parameter int p_decay      = 1,
  parameter int p_spike_clks = 4,
  parameter int p_refrac     = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [6:1]                 i_event,
  input  logic                       i_decay_tick,
  input  logic [3*6*p_width-1:0]     i_weights,
  input  logic [3*(2*p_width+4)-1:0] i_thresholds,
  output logic [6*(p_width+1)-1:0]   o_ts,
  output logic [3*(2*p_width+4)-1:0] o_lv,
  output logic [3:1]                 o_spikeout,
  output logic                       o_busy
);
  localparam int tw = p_width + 1;
  localparam int lw = 2 * p_width + 4;
  localparam int cw = $clog2(p_spike_clks + p_refrac + 8);
`ifdef L2_REFRACTORY_EN
  typedef enum logic [2:0] {IDLE, MAC, CMP, SPIKE, REFRAC} state_t;
`else
  typedef enum logic [1:0] {IDLE, MAC, CMP, SPIKE} state_t;
`endif
  state_t state;
  logic [5:0] ev, pending;
  logic [cw-1:0] cnt;
  logic [2:0] mi, win;
  logic [tw-1:0] trace [6];
  logic [tw-1:0] trace_nxt [6];
  logic [tw-1:0] snap [6];
  logic [p_width-1:0] w [3][6];
  logic [lw-1:0] thr [3];
  logic [lw-1:0] acc [3];
  logic [lw-1:0] best;
  logic [2*p_width-1:0] prod [3];
  assign ev = i_event;
  assign mi = cnt[2:0];
  assign o_busy = state != IDLE;
  for (genvar k = 0; k < 6; k++) begin : g_ts
    assign o_ts[k*tw +: tw] = snap[k];
  end
  // Winner scan keeps the first strictly larger potential, so ties resolve to the lowest neuron.
  always_comb begin
    best = '0;
    win = '0;
    for (int n = 0; n < 3; n++) begin
      thr[n] = i_thresholds[n*lw +: lw];
      for (int k = 0; k < 6; k++) w[n][k] = i_weights[(n*6+k)*p_width +: p_width];
      prod[n] = (2*p_width)'(w[n][mi]) * (2*p_width)'(snap[mi][p_width-1:0]);
      if (acc[n] > thr[n] && (win == '0 || acc[n] > best)) begin
        best = acc[n];
        win = 3'(1 << n);
      end
    end
    for (int k = 0; k < 6; k++)
      trace_nxt[k] = ev[k] ? tw'(p_ts_max) : !i_decay_tick ? trace[k] :
                     trace[k] > tw'(p_decay) ? trace[k] - tw'(p_decay) : '0;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      pending <= '0;
      cnt <= '0;
      o_spikeout <= '0;
      o_lv <= '0;
      for (int k = 0; k < 6; k++) begin
        trace[k] <= '0;
        snap[k] <= '0;
      end
      for (int n = 0; n < 3; n++) acc[n] <= '0;
    end else begin
      for (int k = 0; k < 6; k++) trace[k] <= trace_nxt[k];
      // Events seen while busy are remembered; IDLE consumes them when it starts an evaluation.
      pending <= pending | ev;
      case (state)
        IDLE: if (|(ev | pending)) begin
          for (int k = 0; k < 6; k++) snap[k] <= trace_nxt[k];
          for (int n = 0; n < 3; n++) acc[n] <= '0;
          pending <= '0;
          cnt <= '0;
          state <= MAC;
        end
        MAC: begin
          for (int n = 0; n < 3; n++) acc[n] <= acc[n] + lw'(prod[n]);
          cnt <= cnt + cw'(1);
          if (mi == 3'd5) state <= CMP;
        end
        CMP: begin
          for (int n = 0; n < 3; n++) o_lv[n*lw +: lw] <= acc[n];
          o_spikeout <= win;
          cnt <= '0;
          state <= win == '0 ? IDLE : SPIKE;
        end
        SPIKE: if (cnt == cw'(p_spike_clks - 1)) begin
          o_spikeout <= '0;
          cnt <= '0;
`ifdef L2_REFRACTORY_EN
          state <= REFRAC;
`else
          state <= IDLE;
`endif
        end else cnt <= cnt + cw'(1);
`ifdef L2_REFRACTORY_EN
        // Refractory events still load traces but never schedule an evaluation.
        REFRAC: begin
          pending <= pending;
          cnt <= cnt + cw'(1);
          if (cnt == cw'(p_refrac - 1)) state <= IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_l2_neuron_layer.sv
// tb_l2_neuron_layer: scoreboard bench for l2_neuron_layer against a cycle-count reference model
module tb_l2_neuron_layer;
  localparam int W = 8, LW = 20, TW = 9, TS_MAX = 255, DECAY = 1, SPK = 4, RFR = 16;
`ifdef L2_REFRACTORY_EN
  localparam bit REFRAC = 1'b1;
`else
  localparam bit REFRAC = 1'b0;
`endif
  typedef struct packed {
    logic [2:0][LW-1:0] lv;
    logic [5:0][TW-1:0] ts;
    logic [2:0] sp;
    int endc;
  } exp_t;
  logic clk = 0, rst_n = 0, i_decay_tick = 0;
  logic [6:1] i_event = '0;
  logic [3*6*W-1:0] i_weights;
  logic [3*LW-1:0] i_thresholds;
  logic [6*TW-1:0] o_ts;
  logic [3*LW-1:0] o_lv;
  logic [3:1] o_spikeout;
  logic o_busy;
  logic [7:0] w [3][6];
  int thr [3];
  int m_tr [6];
  int cyc = 0, free_at = 0, rec_until = 0, n_checks = 0, n_err = 0, sp_cnt = 0;
  bit m_pend = 0, prev_busy = 0;
  logic [2:0] sp_acc = '0, last_spike = '0;
  exp_t sb [$];
  exp_t mx;

  l2_neuron_layer dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_event(i_event), .i_decay_tick(i_decay_tick),
    .i_weights(i_weights), .i_thresholds(i_thresholds), .o_ts(o_ts), .o_lv(o_lv),
    .o_spikeout(o_spikeout), .o_busy(o_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    for (int n = 0; n < 3; n++) begin
      i_thresholds[n*LW +: LW] = LW'(thr[n]);
      for (int k = 0; k < 6; k++) i_weights[(n*6+k)*W +: W] = w[n][k];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: potentials are plain dot products, winner is the largest eligible (lowest index on ties),
  // and busy time is 8 cycles without a spike, 8+SPK with one, plus RFR refractory when enabled.
  task automatic evaluate(input int s [6], input int e);
    exp_t x;
    int p, win, best;
    x = '0;
    win = -1;
    best = 0;
    for (int n = 0; n < 3; n++) begin
      p = 0;
      for (int k = 0; k < 6; k++) p += int'(w[n][k]) * (s[k] % 256);
      x.lv[n] = LW'(p);
      if (p > thr[n] && (win < 0 || p > best)) begin
        win = n;
        best = p;
      end
    end
    for (int k = 0; k < 6; k++) x.ts[k] = TW'(s[k]);
    x.sp = win < 0 ? 3'b000 : 3'(1 << win);
    rec_until = e + (win < 0 ? 8 : 8 + SPK);
    free_at = rec_until + ((REFRAC && win >= 0) ? RFR : 0);
    x.endc = free_at - 1;
    sb.push_back(x);
  endtask

  task automatic step(input logic [5:0] ev, input bit tick);
    int nt [6];
    int e;
    i_event = ev;
    i_decay_tick = tick;
    e = cyc + 1;
    for (int k = 0; k < 6; k++)
      nt[k] = ev[k] ? TS_MAX : !tick ? m_tr[k] : (m_tr[k] > DECAY ? m_tr[k] - DECAY : 0);
    if (e >= free_at) begin
      if (ev != 0 || m_pend) begin
        evaluate(nt, e);
        m_pend = 0;
      end
    end else if (e < rec_until) m_pend = m_pend | (ev != 0);
    m_tr = nt;
    @(posedge clk);
    #1;
    i_event = '0;
    i_decay_tick = 0;
  endtask

  task automatic wait_idle();
    int g = 0;
    while ((cyc < free_at || m_pend) && g < 300) begin
      step(6'b0, 0);
      g++;
    end
    check("sb_drain", 64'(sb.size()), 0);
  endtask

  task automatic set_all(input logic [7:0] wv, input int tv);
    for (int n = 0; n < 3; n++) begin
      thr[n] = tv;
      for (int k = 0; k < 6; k++) w[n][k] = wv;
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_busy = 0;
      sp_acc = '0;
      sp_cnt = 0;
    end else begin
      if (o_spikeout != 0) begin
        check("spike_onehot", 64'($countones(o_spikeout)), 1);
        sp_acc = sp_acc | o_spikeout;
        sp_cnt++;
      end
      if (prev_busy && !o_busy) begin
        check("eval_expected", 64'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          mx = sb.pop_front();
          check("lv", o_lv, mx.lv);
          check("ts", o_ts, mx.ts);
          check("spike", sp_acc, mx.sp);
          check("spike_len", 64'(sp_cnt), mx.sp != 0 ? SPK : 0);
          check("end_cycle", 64'(cyc), 64'(mx.endc));
        end
        last_spike = sp_acc;
        sp_acc = '0;
        sp_cnt = 0;
      end
      prev_busy = o_busy;
    end
  end

  initial begin
    set_all(8'h00, 0);
    for (int k = 0; k < 6; k++) m_tr[k] = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_spike", o_spikeout, 0);
    check("rst_lv", o_lv, 0);
    check("rst_ts", o_ts, 0);
    check("rst_busy", o_busy, 0);
    rst_n = 1;
    // Single event, three-way tie resolves to neuron 1
    set_all(8'h7f, 'h06000);
    step(6'b000001, 0);
    wait_idle();
    check("t2_lv", o_lv, {3{20'h07e81}});
    check("t2_ts1", o_ts[TW-1:0], 'hff);
    check("t2_spike", last_spike, 3'b001);
    // Neuron 1 weakened below threshold, neuron 2 wins the tie with neuron 3
    for (int k = 0; k < 6; k++) w[0][k] = 8'h10;
    step(6'b000001, 0);
    wait_idle();
    check("t3_lv1", o_lv[LW-1:0], 'hff0);
    check("t3_spike", last_spike, 3'b010);
    // Unreachable thresholds: potentials update, no spike
    for (int n = 0; n < 3; n++) thr[n] = 'hfffff;
    step(6'b000100, 0);
    wait_idle();
    check("t4_spike", last_spike, 3'b000);
    // Asynchronous reset in the middle of a spike
    set_all(8'h7f, 'h06000);
    step(6'b000001, 0);
    repeat (8) step(6'b0, 0);
    check("pre_reset_spike", o_spikeout, 3'b001);
    #2 rst_n = 0;
    #1;
    check("mid_rst_spike", o_spikeout, 0);
    check("mid_rst_lv", o_lv, 0);
    check("mid_rst_ts", o_ts, 0);
    check("mid_rst_busy", o_busy, 0);
    sb.delete();
    for (int k = 0; k < 6; k++) m_tr[k] = 0;
    free_at = 0;
    rec_until = 0;
    m_pend = 0;
    @(posedge clk);
    #1 rst_n = 1;
    // Decay saturates at zero; event beats a simultaneous tick
    for (int n = 0; n < 3; n++) thr[n] = 'hfffff;
    step(6'b000001, 0);
    repeat (300) step(6'b0, 1);
    step(6'b000010, 0);
    wait_idle();
    check("t5_sat", o_ts[TW-1:0], 0);
    step(6'b000001, 1);
    wait_idle();
    check("t5_evt_wins", o_ts[TW-1:0], 'hff);
    // Event arriving mid-evaluation starts a second evaluation afterwards
    set_all(8'h7f, 'h06000);
    step(6'b000001, 0);
    step(6'b0, 0);
    step(6'b0, 0);
    step(6'b000010, 0);
    wait_idle();
    check("t6_snap_nz", 64'(o_ts[TW-1:0] != 0 && o_ts[2*TW-1:TW] != 0), 1);
    step(6'b000001, 0);
    repeat (13) step(6'b0, 0);
    step(6'b000010, 0);
    wait_idle();
    // Randomized traffic
    for (int r = 0; r < 4; r++) begin
      for (int n = 0; n < 3; n++) begin
        thr[n] = $urandom_range(150000, 0);
        for (int k = 0; k < 6; k++) w[n][k] = 8'($urandom);
      end
      repeat (400) step($urandom_range(5, 0) == 0 ? 6'($urandom) : 6'b0, 1'($urandom));
      wait_idle();
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
